// File: rtl/exit_zone_detector_if.sv
// Frame-rate position/keyboard inputs and the zone/start outputs of the exit zone detector.
// master drives the inputs; slave is the detector.
interface exit_zone_detector_if;
  logic       frame_tick;
  logic       enable;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [7:0] keycode;
  logic [1:0] zone_code;
  logic       zone_change;
  logic       start_pulse;

  modport master (
    output frame_tick, enable, player_x, player_y, keycode,
    input  zone_code, zone_change, start_pulse
  );

  modport slave (
    input  frame_tick, enable, player_x, player_y, keycode,
    output zone_code, zone_change, start_pulse
  );
endinterface

// File: rtl/exit_zone_detector.sv
// Filters per-frame screen-edge exits into a stable zone code (dwell to lock, release to unlock)
// and turns the Enter keycode rising edge into a one-cycle start pulse.
module exit_zone_detector #(
  parameter int unsigned LEFT_EDGE      = 16,
  parameter int unsigned RIGHT_EDGE     = 623,
  parameter int unsigned TOP_EDGE       = 16,
  parameter int unsigned HYST           = 8,
  parameter int unsigned DWELL_FRAMES   = 4,
  parameter int unsigned RELEASE_FRAMES = 2
) (
  input  logic vga_clk,
  input  logic Reset,
  exit_zone_detector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, LOCKED, REL} state_t;

  localparam logic [1:0]  ZONE_NONE  = 2'b00;
  localparam logic [1:0]  ZONE_LEFT  = 2'b01;
  localparam logic [1:0]  ZONE_RIGHT = 2'b10;
  localparam logic [1:0]  ZONE_UP    = 2'b11;
  localparam logic [7:0]  KEY_ENTER  = 8'h28;

  // 11-bit limits so edge +/- HYST cannot overflow the 10-bit coordinates.
  localparam logic [10:0] LEFT_LIM    = 11'(LEFT_EDGE);
  localparam logic [10:0] LEFT_LIM_H  = 11'(LEFT_EDGE + HYST);
  localparam logic [10:0] RIGHT_LIM   = 11'(RIGHT_EDGE);
  localparam logic [10:0] RIGHT_LIM_H = 11'(RIGHT_EDGE - HYST);
  localparam logic [10:0] TOP_LIM     = 11'(TOP_EDGE);
  localparam logic [10:0] TOP_LIM_H   = 11'(TOP_EDGE + HYST);
  localparam logic [7:0]  DWELL_CNT   = 8'(DWELL_FRAMES);
  localparam logic [7:0]  REL_CNT     = 8'(RELEASE_FRAMES);

  state_t     state_q, state_d;
  logic [1:0] zone_q, zone_d;
  logic [1:0] pend_q, pend_d;
  logic [7:0] cnt_q, cnt_d;
  logic       change_q, change_d;
  logic       start_q, start_d;
  logic [7:0] key_prev_q;

  logic [10:0] x_w, y_w;
  logic        relax;
  logic [1:0]  cand;
  logic [7:0]  cnt_inc;

  assign x_w     = {1'b0, bus.player_x};
  assign y_w     = {1'b0, bus.player_y};
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    relax = (state_q == LOCKED) || (state_q == REL);
    cand  = ZONE_NONE;
    if (x_w <= ((relax && zone_q == ZONE_LEFT) ? LEFT_LIM_H : LEFT_LIM)) begin
      cand = ZONE_LEFT;
    end else if (x_w >= ((relax && zone_q == ZONE_RIGHT) ? RIGHT_LIM_H : RIGHT_LIM)) begin
      cand = ZONE_RIGHT;
    end else if (y_w <= ((relax && zone_q == ZONE_UP) ? TOP_LIM_H : TOP_LIM)) begin
      cand = ZONE_UP;
    end
  end

  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    if (!bus.enable) begin
      state_d = IDLE;
      zone_d  = ZONE_NONE;
      pend_d  = ZONE_NONE;
      cnt_d   = 8'd0;
    end else if (bus.frame_tick) begin
      case (state_q)
        IDLE: begin
          if (cand != ZONE_NONE) begin
            if (DWELL_CNT == 8'd1) begin
              zone_d  = cand;
              state_d = LOCKED;
            end else begin
              pend_d  = cand;
              cnt_d   = 8'd1;
              state_d = ARM;
            end
          end
        end
        ARM: begin
          if (cand == pend_q) begin
            if (cnt_inc == DWELL_CNT) begin
              zone_d  = pend_q;
              cnt_d   = 8'd0;
              state_d = LOCKED;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (cand == ZONE_NONE) begin
            cnt_d   = 8'd0;
            state_d = IDLE;
          end else begin
            pend_d = cand;
            cnt_d  = 8'd1;
          end
        end
        LOCKED: begin
          if (cand != zone_q) begin
            if (REL_CNT == 8'd1) begin
              zone_d  = ZONE_NONE;
              state_d = IDLE;
            end else begin
              cnt_d   = 8'd1;
              state_d = REL;
            end
          end
        end
        default: begin // REL
          if (cand == zone_q) begin
            cnt_d   = 8'd0;
            state_d = LOCKED;
          end else if (cnt_inc == REL_CNT) begin
            zone_d  = ZONE_NONE;
            cnt_d   = 8'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
    change_d = (zone_d != zone_q);
    start_d  = (bus.keycode == KEY_ENTER) && (key_prev_q != KEY_ENTER);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      zone_q     <= ZONE_NONE;
      pend_q     <= ZONE_NONE;
      cnt_q      <= 8'd0;
      change_q   <= 1'b0;
      start_q    <= 1'b0;
      key_prev_q <= KEY_ENTER;
    end else begin
      state_q    <= state_d;
      zone_q     <= zone_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      change_q   <= change_d;
      start_q    <= start_d;
      key_prev_q <= bus.keycode;
    end
  end

  assign bus.zone_code   = zone_q;
  assign bus.zone_change = change_q;
  assign bus.start_pulse = start_q;

endmodule

// File: tb/tb_exit_zone_detector.sv
// Bench for exit_zone_detector: directed literal checks plus randomized frames checked
// every cycle against a frame-streak model of the zone filter.
module tb_exit_zone_detector;
  localparam int LEFT_EDGE = 16, RIGHT_EDGE = 623, TOP_EDGE = 16, HYST = 8;
  localparam int DWELL = 4, RELEASE = 2;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  exit_zone_detector_if bus();

  exit_zone_detector dut (
    .vga_clk (clk),
    .Reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model: locked zone, length of the current same-zone streak while unlocked,
  // length of the current mismatch run while locked.
  int   m_lock, m_pend, m_streak, m_miss;
  logic m_chg, m_start, m_valid = 1'b0;
  logic [7:0] m_kprev;

  function automatic int cand_f(input int x, input int y, input int lz);
    int l, r, t;
    l = LEFT_EDGE  + ((lz == 1) ? HYST : 0);
    r = RIGHT_EDGE - ((lz == 2) ? HYST : 0);
    t = TOP_EDGE   + ((lz == 3) ? HYST : 0);
    if (x <= l) return 1;
    if (x >= r) return 2;
    if (y <= t) return 3;
    return 0;
  endfunction

  always @(posedge clk) begin
    int lz, pz, st, ms, c;
    logic chg, sp;
    lz = m_lock; pz = m_pend; st = m_streak; ms = m_miss;
    chg = 1'b0;
    if (rst) begin
      m_lock <= 0; m_pend <= 0; m_streak <= 0; m_miss <= 0;
      m_kprev <= 8'h28; m_chg <= 1'b0; m_start <= 1'b0; m_valid <= 1'b1;
    end else begin
      sp = (bus.keycode == 8'h28) && (m_kprev != 8'h28);
      if (!bus.enable) begin
        chg = (lz != 0); lz = 0; st = 0; ms = 0;
      end else if (bus.frame_tick) begin
        c = cand_f(int'(bus.player_x), int'(bus.player_y), lz);
        if (lz == 0) begin
          if (c == 0) st = 0;
          else if (c == pz && st > 0) st = st + 1;
          else begin pz = c; st = 1; end
          if (st == DWELL) begin lz = c; st = 0; chg = 1'b1; end
        end else begin
          if (c == lz) ms = 0;
          else ms = ms + 1;
          if (ms == RELEASE) begin lz = 0; ms = 0; chg = 1'b1; end
        end
      end
      m_lock <= lz; m_pend <= pz; m_streak <= st; m_miss <= ms;
      m_kprev <= bus.keycode; m_chg <= chg; m_start <= sp;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks = checks + 1;
      if (int'(bus.zone_code) != m_lock || bus.zone_change != m_chg || bus.start_pulse != m_start) begin
        errors = errors + 1;
        $display("FAIL model t=%0t: zone/chg/start got %0d/%0b/%0b expected %0d/%0b/%0b",
                 $time, bus.zone_code, bus.zone_change, bus.start_pulse, m_lock, m_chg, m_start);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic tick(input int x, input int y);
    bus.player_x = 10'(x);
    bus.player_y = 10'(y);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  logic [7:0] keys [6] = '{8'h00, 8'h28, 8'h28, 8'h28, 8'h00, 8'h28};
  int         kexp [6] = '{0, 1, 0, 0, 0, 1};

  initial begin
    bus.frame_tick = 1'b0; bus.enable = 1'b1; bus.keycode = 8'h00;
    bus.player_x = 10'd300; bus.player_y = 10'd200;
    rst = 1'b1;
    step(); step();
    chk("reset_zone", int'(bus.zone_code), 0);
    chk("reset_chg", int'(bus.zone_change), 0);
    chk("reset_start", int'(bus.start_pulse), 0);
    rst = 1'b0;
    step();

    // Dwell on the left edge.
    for (int i = 0; i < 3; i++) tick(10, 200);
    chk("dwell3_zone", int'(bus.zone_code), 0);
    tick(10, 200);
    chk("dwell4_zone", int'(bus.zone_code), 1);
    chk("dwell4_chg", int'(bus.zone_change), 1);
    step();
    chk("dwell4_chg_once", int'(bus.zone_change), 0);

    // Hysteresis holds, then release.
    for (int i = 0; i < 5; i++) tick(20, 200);
    chk("hyst_hold", int'(bus.zone_code), 1);
    tick(30, 200);
    chk("rel1_zone", int'(bus.zone_code), 1);
    tick(30, 200);
    chk("rel2_zone", int'(bus.zone_code), 0);
    chk("rel2_chg", int'(bus.zone_change), 1);

    // Right interrupted by left: pend restarts.
    tick(630, 200); tick(630, 200);
    for (int i = 0; i < 3; i++) tick(5, 200);
    chk("rearm3_zone", int'(bus.zone_code), 0);
    tick(5, 200);
    chk("rearm4_zone", int'(bus.zone_code), 1);

    // Priority left over up, then up alone.
    bus.enable = 1'b0; step(); bus.enable = 1'b1;
    chk("clear_chg", int'(bus.zone_change), 1);
    for (int i = 0; i < 4; i++) tick(10, 5);
    chk("prio_zone", int'(bus.zone_code), 1);
    bus.enable = 1'b0; step(); bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) tick(300, 5);
    chk("up_zone", int'(bus.zone_code), 3);

    // Mid-frame disable, then ticks ignored while disabled.
    bus.enable = 1'b0; step();
    chk("dis_zone", int'(bus.zone_code), 0);
    chk("dis_chg", int'(bus.zone_change), 1);
    for (int i = 0; i < 4; i++) tick(10, 200);
    chk("dis_ticks_zone", int'(bus.zone_code), 0);
    chk("dis_ticks_chg", int'(bus.zone_change), 0);
    bus.enable = 1'b1;
    step();

    // Enter edge detection.
    for (int i = 0; i < 6; i++) begin
      bus.keycode = keys[i];
      step();
      chk($sformatf("key%0d_start", i), int'(bus.start_pulse), kexp[i]);
    end
    step();
    rst = 1'b1; step(); step(); rst = 1'b0;
    step();
    chk("enter_reset_start_a", int'(bus.start_pulse), 0);
    step();
    chk("enter_reset_start_b", int'(bus.start_pulse), 0);

    // Randomized frames near the edges.
    for (int i = 0; i < 4000; i++) begin
      int r;
      rst = ($urandom_range(0, 499) == 0);
      bus.enable = ($urandom_range(0, 79) != 0);
      bus.frame_tick = ($urandom_range(0, 3) == 0);
      if (bus.frame_tick && $urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 3);
        case (r)
          0: bus.player_x = 10'($urandom_range(0, 40));
          1: bus.player_x = 10'($urandom_range(600, 1023));
          default: bus.player_x = 10'($urandom_range(0, 1023));
        endcase
        bus.player_y = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 40))
                                                    : 10'($urandom_range(0, 1023));
      end
      r = $urandom_range(0, 3);
      bus.keycode = (r < 2) ? 8'h28 : ((r == 2) ? 8'h00 : 8'($urandom_range(0, 255)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
